// File: rtl/auth_initiator_pkg.sv
// auth_initiator_pkg: message-type codes, USB request numbers, error codes,
// header geometry, default timeouts, FSM state encoding and small helpers
// shared by the authentication initiator and its timer.
package auth_initiator_pkg;

  // Header geometry: four one-byte fields {Ver, Type, Param1, Param2}
  localparam int          HDR_FIELD_W = 8;
  localparam int          HDR_BYTES   = 4;
  localparam logic [7:0]  HDR_VER     = 8'h01;

  // Request message types
  localparam logic [7:0]  MSG_GET_DIGESTS     = 8'h81;
  localparam logic [7:0]  MSG_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0]  MSG_CHALLENGE       = 8'h83;
  // Response message types
  localparam logic [7:0]  MSG_DIGESTS         = 8'h01;
  localparam logic [7:0]  MSG_CERTIFICATE     = 8'h02;
  localparam logic [7:0]  MSG_CHALLENGE_AUTH  = 8'h03;
  localparam logic [7:0]  MSG_ERROR           = 8'h7F;

  // USB setup fields
  localparam logic [7:0]  AUTH_IN     = 8'd24;
  localparam logic [7:0]  AUTH_OUT    = 8'd25;
  localparam logic [7:0]  BM_REQ_TYPE = 8'h00;

  // err_code values
  localparam logic [7:0]  ERR_NONE     = 8'h00;
  localparam logic [7:0]  ERR_VER      = 8'h01;
  localparam logic [7:0]  ERR_TYPE     = 8'h02;
  localparam logic [7:0]  ERR_TIMEOUT  = 8'h03;
  localparam logic [7:0]  ERR_ILLEGAL  = 8'h04;
  localparam logic [7:0]  ERR_RSP_BASE = 8'h80;

  // Default timeouts (cycles)
  localparam logic [31:0] DEF_DIGEST_TO = 32'd1000;
  localparam logic [31:0] DEF_CERT_TO   = 32'd1000;
  localparam logic [31:0] DEF_CHAL_TO   = 32'd2000;

  // req_type encodings
  localparam logic [1:0]  REQ_DIGESTS = 2'd0;
  localparam logic [1:0]  REQ_CERT    = 2'd1;
  localparam logic [1:0]  REQ_CHAL    = 2'd2;
  localparam logic [1:0]  REQ_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_CHECK    = 3'd3,
    ST_ACK      = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  // Request Type byte for a legal req_type
  function automatic logic [7:0] req_msg_type(input logic [1:0] rt);
    case (rt)
      REQ_DIGESTS: return MSG_GET_DIGESTS;
      REQ_CERT:    return MSG_GET_CERTIFICATE;
      default:     return MSG_CHALLENGE;
    endcase
  endfunction

  // Response Type byte the responder must answer a req_type with
  function automatic logic [7:0] rsp_msg_type(input logic [1:0] rt);
    case (rt)
      REQ_DIGESTS: return MSG_DIGESTS;
      REQ_CERT:    return MSG_CERTIFICATE;
      default:     return MSG_CHALLENGE_AUTH;
    endcase
  endfunction

  // wLength = header bytes + payload bytes (none / offset+length / nonce)
  function automatic logic [15:0] req_wlength(input logic [1:0] rt);
    case (rt)
      REQ_DIGESTS: return 16'(HDR_BYTES);
      REQ_CERT:    return 16'(HDR_BYTES) + 16'd4;
      default:     return 16'(HDR_BYTES) + 16'd32;
    endcase
  endfunction

endpackage

// File: rtl/auth_timer.sv
// auth_timer: loadable 32-bit down-counter used for response timeouts.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   load          load load_val (has priority over en)
//   en            decrement once per cycle, saturating at 0
//   load_val      value to load
//   expired       count is 0
module auth_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Counter register: load wins over decrement, holds at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/auth_initiator.sv
// auth_initiator: requesting side of the USB Type-C authentication exchange.
// Builds GET_DIGESTS / GET_CERTIFICATE / CHALLENGE, holds it to the responder,
// waits with a per-type timeout and bounded retries, validates the response
// header, acks the responder and reports done/error to the policy host.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, req_type, slot      request strobe (IDLE only), type, cert slot
//   cert_off_len, nonce        request payload sources
//   init_req_out, auth_msg_out request valid and message to responder
//   bmRequestType, bRequest, wLength  USB setup fields
//   resp_req_in, rsp_header_in, rsp_payload_in  response from responder
//   ack_out                    one-cycle ack to responder
//   rsp_header, rsp_payload    latched response
//   busy, done, error, err_code  status to policy host
module auth_initiator
  import auth_initiator_pkg::*;
#(
  parameter int          MSG_LEN   = 544,
  parameter logic [31:0] DIGEST_TO = DEF_DIGEST_TO,
  parameter logic [31:0] CERT_TO   = DEF_CERT_TO,
  parameter logic [31:0] CHAL_TO   = DEF_CHAL_TO,
  parameter int          MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          req_type,
  input  logic [1:0]          slot,
  input  logic [31:0]         cert_off_len,
  input  logic [255:0]        nonce,
  output logic                init_req_out,
  output logic [MSG_LEN-1:0]  auth_msg_out,
  output logic [7:0]          bmRequestType,
  output logic [7:0]          bRequest,
  output logic [15:0]         wLength,
  input  logic                resp_req_in,
  input  logic [31:0]         rsp_header_in,
  input  logic [MSG_LEN-33:0] rsp_payload_in,
  output logic                ack_out,
  output logic [31:0]         rsp_header,
  output logic [MSG_LEN-33:0] rsp_payload,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          err_code
);

  state_t               state, next_state;
  logic [1:0]           req_type_r;
  logic [7:0]           retry_r;
  logic [7:0]           chk_code, chk_code_r;
  logic [MSG_LEN-1:0]   req_msg;
  logic [31:0]          timeout_val;
  logic                 timer_load, timer_en, timer_expired;
  logic                 accept;

  assign accept = (state == ST_IDLE) && start && (req_type != REQ_ILLEGAL);

  auth_timer #(.W(32)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (timeout_val),
    .expired  (timer_expired)
  );

  // Request message: header in the MSBs, payload left-aligned beneath it
  always_comb begin
    req_msg = '0;
    req_msg[MSG_LEN-1 -: 32] = {HDR_VER, req_msg_type(req_type), 6'b000000, slot, 8'h00};
    case (req_type)
      REQ_CERT: req_msg[MSG_LEN-33 -: 32]  = cert_off_len;
      REQ_CHAL: req_msg[MSG_LEN-33 -: 256] = nonce;
      default:  begin end
    endcase
  end

  // Timeout for the request in flight
  always_comb begin
    case (req_type_r)
      REQ_DIGESTS: timeout_val = DIGEST_TO;
      REQ_CERT:    timeout_val = CERT_TO;
      default:     timeout_val = CHAL_TO;
    endcase
  end

  // Response header validation; version outranks an ERROR message
  always_comb begin
    chk_code = ERR_NONE;
    if (rsp_header[31:24] != HDR_VER) begin
      chk_code = ERR_VER;
    end else if (rsp_header[23:16] == MSG_ERROR) begin
      chk_code = ERR_RSP_BASE | rsp_header[15:8];
    end else if (rsp_header[23:16] != rsp_msg_type(req_type_r)) begin
      chk_code = ERR_TYPE;
    end else begin
      chk_code = ERR_NONE;
    end
  end

  // Next-state logic and timer control
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (req_type == REQ_ILLEGAL) ? ST_ERROR : ST_SEND;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SEND: begin
        timer_load = 1'b1;
        next_state = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // A response arriving on the expiry cycle still wins
        if (resp_req_in) begin
          next_state = ST_CHECK;
        end else if (timer_expired) begin
          next_state = (retry_r < 8'(MAX_RETRY)) ? ST_GAP : ST_ERROR;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_GAP:   next_state = ST_SEND;
      ST_CHECK: next_state = ST_ACK;
      ST_ACK:   next_state = (chk_code_r == ERR_NONE) ? ST_DONE : ST_ERROR;
      ST_DONE:  next_state = ST_IDLE;
      ST_ERROR: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered outputs and datapath, all decoded from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      init_req_out  <= 1'b0;
      ack_out       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 8'h00;
      auth_msg_out  <= '0;
      bmRequestType <= 8'h00;
      bRequest      <= 8'h00;
      wLength       <= 16'h0000;
      rsp_header    <= 32'h0;
      rsp_payload   <= '0;
      req_type_r    <= 2'd0;
      retry_r       <= 8'd0;
      chk_code_r    <= 8'h00;
    end else begin
      // Request stays valid through CHECK; dropped for GAP and ACK
      init_req_out <= next_state inside {ST_SEND, ST_WAIT_RSP, ST_CHECK};
      ack_out      <= (next_state == ST_ACK);
      busy         <= next_state inside {ST_SEND, ST_WAIT_RSP, ST_GAP, ST_CHECK, ST_ACK};
      done         <= (next_state == ST_DONE);
      error        <= (next_state == ST_ERROR);

      if (accept) begin
        auth_msg_out  <= req_msg;
        bmRequestType <= BM_REQ_TYPE;
        bRequest      <= AUTH_OUT;
        wLength       <= req_wlength(req_type);
        req_type_r    <= req_type;
        retry_r       <= 8'd0;
        err_code      <= ERR_NONE;
      end else if ((next_state == ST_ERROR) && (state != ST_ERROR)) begin
        case (state)
          ST_IDLE:     err_code <= ERR_ILLEGAL;
          ST_WAIT_RSP: err_code <= ERR_TIMEOUT;
          default:     err_code <= chk_code_r;
        endcase
      end else begin
        err_code <= err_code;
      end

      if ((state == ST_WAIT_RSP) && (next_state == ST_GAP)) begin
        retry_r <= retry_r + 8'd1;
      end else begin
        retry_r <= retry_r;
      end

      if ((state == ST_WAIT_RSP) && resp_req_in) begin
        rsp_header  <= rsp_header_in;
        rsp_payload <= rsp_payload_in;
      end else begin
        rsp_header  <= rsp_header;
        rsp_payload <= rsp_payload;
      end

      if (state == ST_CHECK) begin
        chk_code_r <= chk_code;
      end else begin
        chk_code_r <= chk_code_r;
      end
    end
  end

endmodule

// File: tb/tb_auth_initiator.sv
// Self-checking bench for auth_initiator with a behavioural request/response
// model and a simple responder that answers after a chosen number of cycles.
module tb_auth_initiator;

  localparam int          ML       = 544;
  localparam logic [31:0] TB_DIG   = 32'd12;
  localparam logic [31:0] TB_CERT  = 32'd8;
  localparam logic [31:0] TB_CHAL  = 32'd16;
  localparam int          TB_RETRY = 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    req_type, slot;
  logic [31:0]   cert_off_len;
  logic [255:0]  nonce;
  logic          init_req_out;
  logic [ML-1:0] auth_msg_out;
  logic [7:0]    bmRequestType, bRequest;
  logic [15:0]   wLength;
  logic          resp_req_in;
  logic [31:0]   rsp_header_in;
  logic [ML-33:0] rsp_payload_in;
  logic          ack_out;
  logic [31:0]   rsp_header;
  logic [ML-33:0] rsp_payload;
  logic          busy, done, error;
  logic [7:0]    err_code;

  int n_checks = 0;
  int n_fail   = 0;

  auth_initiator #(.MSG_LEN(ML), .DIGEST_TO(TB_DIG), .CERT_TO(TB_CERT),
                   .CHAL_TO(TB_CHAL), .MAX_RETRY(TB_RETRY)) dut (
    .clk(clk), .reset(reset), .start(start), .req_type(req_type), .slot(slot),
    .cert_off_len(cert_off_len), .nonce(nonce), .init_req_out(init_req_out),
    .auth_msg_out(auth_msg_out), .bmRequestType(bmRequestType), .bRequest(bRequest),
    .wLength(wLength), .resp_req_in(resp_req_in), .rsp_header_in(rsp_header_in),
    .rsp_payload_in(rsp_payload_in), .ack_out(ack_out), .rsp_header(rsp_header),
    .rsp_payload(rsp_payload), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [ML-1:0] m_msg(input int rt, input logic [1:0] sl,
                                          input logic [31:0] col, input logic [255:0] nn);
    logic [31:0] hdr;
    hdr = {8'h01, 8'h81 + 8'(rt), 6'd0, sl, 8'h00};
    case (rt)
      0:       return {hdr, 512'd0};
      1:       return {hdr, col, 480'd0};
      default: return {hdr, nn, 256'd0};
    endcase
  endfunction

  function automatic logic [15:0] m_wlen(input int rt);
    int pay_bytes;
    pay_bytes = (rt == 0) ? 0 : (rt == 1) ? 4 : 32;
    return 16'(4 + pay_bytes);
  endfunction

  function automatic logic [7:0] m_code(input int rt, input logic [31:0] h);
    if (h[31:24] != 8'h01) return 8'h01;
    if (h[23:16] == 8'h7F) return 8'h80 | h[15:8];
    if (h[23:16] != 8'(rt + 1)) return 8'h02;
    return 8'h00;
  endfunction

  // ---------------- observations from one transaction ----------------
  int            obs_cyc, obs_rises, obs_acks, obs_dones, obs_errors, obs_extra, obs_busy_drop;
  bit            obs_finished, obs_busy_after;
  logic [7:0]    obs_code, obs_code_accept, obs_code_hold;
  logic [ML-1:0] obs_msg;
  logic [15:0]   obs_wlen;
  logic [7:0]    obs_bm, obs_breq;
  logic [31:0]   obs_rhdr;
  logic [ML-33:0] obs_rpay;
  int            runs[$];
  int            gaps[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and play the responder: answer on the delay-th cycle of
  // the first request (delay<0: never), hold until ack.
  task automatic run_txn(input logic [1:0] rt, input logic [1:0] sl, input logic [31:0] col,
                         input logic [255:0] nn, input int delay, input logic [31:0] rh,
                         input logic [ML-33:0] rp, input bit noise);
    int cyc, run, gap;
    bit prev, finished;
    obs_rises = 0; obs_acks = 0; obs_dones = 0; obs_errors = 0; obs_extra = 0;
    obs_busy_drop = 0; obs_cyc = -1; obs_code = 8'hEE; obs_code_accept = 8'hEE;
    runs.delete(); gaps.delete();
    req_type = rt; slot = sl; cert_off_len = col; nonce = nn;
    rsp_header_in = rh; rsp_payload_in = rp; resp_req_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; run = 0; gap = 0; prev = 1'b0; finished = 1'b0;
    while (!finished && cyc < 300) begin
      if (cyc == 1) obs_code_accept = err_code;
      if (noise) begin
        start = (cyc == 2);
        if (cyc == 2) begin req_type = rt ^ 2'd1; slot = ~sl; end
      end
      if (init_req_out) begin
        if (!prev) begin
          if (obs_rises > 0) gaps.push_back(gap);
          obs_rises++;
          run = 0;
        end
        run++;
        if (obs_rises == 1 && delay >= 0 && run == delay + 1) resp_req_in = 1'b1;
      end else begin
        if (prev) begin runs.push_back(run); gap = 0; end
        gap++;
      end
      if (ack_out) begin obs_acks++; resp_req_in = 1'b0; end
      if (done) obs_dones++;
      if (error) obs_errors++;
      if (done || error) begin
        finished = 1'b1;
        obs_cyc = cyc; obs_code = err_code; obs_msg = auth_msg_out; obs_wlen = wLength;
        obs_bm = bmRequestType; obs_breq = bRequest; obs_rhdr = rsp_header; obs_rpay = rsp_payload;
      end else if (!busy) begin
        obs_busy_drop++;
      end
      prev = init_req_out;
      if (!finished) begin tick(); cyc++; end
    end
    start = 1'b0;
    obs_finished = finished;
    if (finished) begin
      tick();
      obs_extra = (done || error) ? 1 : 0;
      obs_busy_after = busy;
      obs_code_hold = err_code;
    end
    resp_req_in = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; req_type = 2'd0; slot = 2'd0; cert_off_len = 32'd0;
    nonce = 256'd0; resp_req_in = 1'b0; rsp_header_in = 32'd0; rsp_payload_in = '0;
    repeat (3) tick();
    n_checks++; if ({init_req_out, ack_out, busy, done, error} !== 5'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {init_req_out, ack_out, busy, done, error}); end
    n_checks++; if (err_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h want 00", err_code); end
    n_checks++; if (auth_msg_out !== '0) begin n_fail++; $display("FAIL reset_msg: got %h want 0", auth_msg_out); end
    n_checks++; if ({rsp_header, rsp_payload} !== '0) begin n_fail++; $display("FAIL reset_rsp: got %h want 0", rsp_header); end
    n_checks++; if ({bmRequestType, bRequest, wLength} !== 32'd0) begin n_fail++;
      $display("FAIL reset_setup: got %h want 0", {bmRequestType, bRequest, wLength}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_digests();
    logic [31:0]    col;
    logic [ML-33:0] rp;
    col = $urandom();
    for (int i = 0; i < 16; i++) rp[i*32 +: 32] = $urandom();
    run_txn(2'd0, 2'd1, col, 256'd0, 5, 32'h01010000, rp, 1'b0);
    n_checks++; if (obs_msg[ML-1 -: 32] !== 32'h01810100) begin n_fail++; $display("FAIL dig_hdr: got %h want 01810100", obs_msg[ML-1 -: 32]); end
    n_checks++; if (obs_msg !== m_msg(0, 2'd1, col, 256'd0)) begin n_fail++; $display("FAIL dig_msg: got %h", obs_msg); end
    n_checks++; if (obs_wlen !== 16'd4) begin n_fail++; $display("FAIL dig_wlen: got %0d want 4", obs_wlen); end
    n_checks++; if ({obs_bm, obs_breq} !== {8'h00, 8'd25}) begin n_fail++; $display("FAIL dig_setup: got %h want 0019", {obs_bm, obs_breq}); end
    n_checks++; if (obs_acks !== 1) begin n_fail++; $display("FAIL dig_ack: got %0d want 1", obs_acks); end
    n_checks++; if (obs_dones !== 1 || obs_errors !== 0 || obs_extra !== 0) begin n_fail++;
      $display("FAIL dig_done: got done=%0d err=%0d extra=%0d want 1 0 0", obs_dones, obs_errors, obs_extra); end
    n_checks++; if (obs_code !== 8'h00) begin n_fail++; $display("FAIL dig_code: got %h want 00", obs_code); end
    n_checks++; if (obs_cyc !== 9) begin n_fail++; $display("FAIL dig_latency: got %0d want 9", obs_cyc); end
    n_checks++; if (obs_busy_drop !== 0 || obs_busy_after !== 1'b0) begin n_fail++;
      $display("FAIL dig_busy: got drops=%0d after=%b want 0 0", obs_busy_drop, obs_busy_after); end
  endtask

  task automatic test_challenge();
    logic [255:0]   nn;
    logic [ML-33:0] rp;
    nn = {32{8'hA5}};
    for (int i = 0; i < 16; i++) rp[i*32 +: 32] = $urandom();
    run_txn(2'd2, 2'd3, 32'd0, nn, 2, 32'h01030000, rp, 1'b0);
    n_checks++; if (obs_wlen !== 16'd36) begin n_fail++; $display("FAIL chal_wlen: got %0d want 36", obs_wlen); end
    n_checks++; if (obs_msg[ML-33 -: 256] !== nn) begin n_fail++; $display("FAIL chal_nonce: got %h", obs_msg[ML-33 -: 256]); end
    n_checks++; if (obs_rpay !== rp) begin n_fail++; $display("FAIL chal_rpay: got %h want %h", obs_rpay, rp); end
    n_checks++; if (obs_dones !== 1 || obs_cyc !== 6) begin n_fail++;
      $display("FAIL chal_done: got done=%0d at %0d want 1 at 6", obs_dones, obs_cyc); end
  endtask

  task automatic test_timeout();
    int bad;
    run_txn(2'd1, 2'd2, $urandom(), 256'd0, -1, 32'h0, '0, 1'b0);
    n_checks++; if (!obs_finished) begin n_fail++; $display("FAIL to_finish: got no error pulse want error"); end
    n_checks++; if (obs_rises !== 3) begin n_fail++; $display("FAIL to_requests: got %0d want 3", obs_rises); end
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad++;
    n_checks++; if (gaps.size() !== 2 || bad !== 0) begin n_fail++;
      $display("FAIL to_gaps: got %0d gaps (%0d not 1) want 2 gaps of 1", gaps.size(), bad); end
    bad = 0;
    foreach (runs[i]) if (runs[i] != int'(TB_CERT) + 2) bad++;
    n_checks++; if (runs.size() !== 3 || bad !== 0) begin n_fail++;
      $display("FAIL to_req_len: got %0d runs (%0d wrong) want 3 of %0d", runs.size(), bad, int'(TB_CERT) + 2); end
    n_checks++; if (obs_errors !== 1 || obs_acks !== 0 || obs_code !== 8'h03) begin n_fail++;
      $display("FAIL to_error: got err=%0d ack=%0d code=%h want 1 0 03", obs_errors, obs_acks, obs_code); end
    n_checks++; if (obs_code_hold !== 8'h03) begin n_fail++; $display("FAIL to_code_hold: got %h want 03", obs_code_hold); end
  endtask

  task automatic test_rsp_errors();
    logic [31:0] hdrs [3];
    logic [7:0]  codes [3];
    hdrs[0] = 32'h017F0500; codes[0] = 8'h85;
    hdrs[1] = 32'h02010000; codes[1] = 8'h01;
    hdrs[2] = 32'h01020000; codes[2] = 8'h02;
    for (int k = 0; k < 3; k++) begin
      run_txn(2'd0, 2'd0, 32'd0, 256'd0, 3, hdrs[k], '0, 1'b0);
      n_checks++; if (obs_acks !== 1 || obs_errors !== 1 || obs_dones !== 0) begin n_fail++;
        $display("FAIL rsperr_flow%0d: got ack=%0d err=%0d done=%0d want 1 1 0", k, obs_acks, obs_errors, obs_dones); end
      n_checks++; if (obs_code !== codes[k]) begin n_fail++; $display("FAIL rsperr_code%0d: got %h want %h", k, obs_code, codes[k]); end
    end
  endtask

  task automatic test_illegal();
    run_txn(2'd3, 2'd1, 32'd0, 256'd0, 1, 32'h01010000, '0, 1'b0);
    n_checks++; if (obs_rises !== 0 || obs_acks !== 0) begin n_fail++;
      $display("FAIL ill_sent: got req=%0d ack=%0d want 0 0", obs_rises, obs_acks); end
    n_checks++; if (obs_errors !== 1 || obs_code !== 8'h04 || obs_cyc !== 1) begin n_fail++;
      $display("FAIL ill_error: got err=%0d code=%h at %0d want 1 04 at 1", obs_errors, obs_code, obs_cyc); end
  endtask

  task automatic test_ignored();
    logic [31:0] hdr_before;
    int bad;
    hdr_before = rsp_header;
    bad = 0;
    resp_req_in = 1'b1; rsp_header_in = 32'h01010000 ^ $urandom();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || ack_out || init_req_out || rsp_header != hdr_before) bad++;
    end
    resp_req_in = 1'b0;
    tick();
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_resp: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [ML-33:0] rp;
    req_type = 2'd2; nonce = {8{$urandom()}}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_checks++; if (init_req_out !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("FAIL rmid_pre: got req=%b busy=%b want 1 1", init_req_out, busy); end
    reset = 1'b1;
    tick();
    n_checks++; if ({init_req_out, ack_out, busy, done, error, err_code} !== 13'd0 || auth_msg_out !== '0) begin n_fail++;
      $display("FAIL rmid_clear: got ctrl=%b code=%h want 0", {init_req_out, ack_out, busy, done, error}, err_code); end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) rp[i*32 +: 32] = $urandom();
    run_txn(2'd0, 2'd2, 32'd0, 256'd0, 3, 32'h01010000, rp, 1'b0);
    n_checks++; if (obs_dones !== 1 || obs_code !== 8'h00 || obs_cyc !== 7) begin n_fail++;
      $display("FAIL rmid_after: got done=%0d code=%h at %0d want 1 00 at 7", obs_dones, obs_code, obs_cyc); end
  endtask

  task automatic test_random();
    int rt, d, kind;
    logic [1:0] sl;
    logic [31:0] col, rh;
    logic [255:0] nn;
    logic [ML-33:0] rp;
    logic [7:0] p1, p2, ec;
    for (int it = 0; it < 24; it++) begin
      rt = $urandom_range(0, 2); sl = 2'($urandom()); col = $urandom();
      for (int i = 0; i < 8; i++) nn[i*32 +: 32] = $urandom();
      for (int i = 0; i < 16; i++) rp[i*32 +: 32] = $urandom();
      d = $urandom_range(1, 6); kind = $urandom_range(0, 3);
      p1 = 8'($urandom()); p2 = 8'($urandom());
      case (kind)
        0: rh = {8'h01, 8'(rt + 1), p1, p2};
        1: rh = {8'h02 + 8'($urandom_range(0, 7)), 8'(rt + 1), p1, p2};
        2: rh = {8'h01, 8'h7F, p1, 8'h00};
        default: rh = {8'h01, 8'((rt + 1) % 3 + 1), p1, p2};
      endcase
      ec = m_code(rt, rh);
      run_txn(2'(rt), sl, col, nn, d, rh, rp, $urandom_range(0, 1) == 1);
      n_checks++; if (obs_code_accept !== 8'h00) begin n_fail++; $display("FAIL rnd%0d_clear: got %h want 00", it, obs_code_accept); end
      n_checks++; if (obs_code !== ec || obs_dones !== (ec == 0 ? 1 : 0) || obs_errors !== (ec == 0 ? 0 : 1)) begin n_fail++;
        $display("FAIL rnd%0d_result: got code=%h done=%0d err=%0d want code=%h", it, obs_code, obs_dones, obs_errors, ec); end
      n_checks++; if (obs_cyc !== d + 4 || obs_acks !== 1) begin n_fail++;
        $display("FAIL rnd%0d_timing: got %0d ack=%0d want %0d ack=1", it, obs_cyc, obs_acks, d + 4); end
      n_checks++; if (obs_msg !== m_msg(rt, sl, col, nn) || obs_wlen !== m_wlen(rt)) begin n_fail++;
        $display("FAIL rnd%0d_msg: got hdr=%h wlen=%0d want hdr=%h wlen=%0d", it, obs_msg[ML-1 -: 32], obs_wlen,
                 m_msg(rt, sl, col, nn) >> (ML - 32), m_wlen(rt)); end
      n_checks++; if (obs_rhdr !== rh || obs_rpay !== rp) begin n_fail++;
        $display("FAIL rnd%0d_rsp: got hdr=%h want %h", it, obs_rhdr, rh); end
    end
  endtask

  initial begin
    test_reset();
    test_digests();
    test_challenge();
    test_timeout();
    test_rsp_errors();
    test_illegal();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
